pc_redirect_ctrl: RTL and testbench

Sequences control-flow redirection for the five-stage pipeline. Takes the taken-branch decision and target produced in EX, presents a single redirect request to the fetch stage, holds it until fetch accepts, and drives the IF/ID and ID/EX flush lines for exactly the wrong-path window. It sits between the EX-stage branch logic and the IF-stage PC register.

---
 rtl/bru_pkg.sv | 14 +
 rtl/bru_perf_cnt.sv | 34 +++
 rtl/pc_redirect_ctrl.sv | 116 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bru_pkg.sv
// Shared types and defaults for the PC redirect controller.
package bru_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    SQUASH = 2'd2
  } bru_state_e;

  localparam int BRU_SQUASH_CYC_DEF = 1;

  typedef logic [31:0] bru_cnt_t;

endpackage

// File: rtl/bru_perf_cnt.sv
// Free-running performance counters for accepted redirects and fetch-wait cycles.
module bru_perf_cnt
  import bru_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_taken,
  input  logic        inc_wait,
  output logic [31:0] taken_cnt,
  output logic [31:0] wait_cnt
);

  bru_cnt_t taken_q, taken_d;
  bru_cnt_t wait_q,  wait_d;

  always_comb begin
    taken_d = taken_q + bru_cnt_t'(inc_taken);
    wait_d  = wait_q  + bru_cnt_t'(inc_wait);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q <= '0;
      wait_q  <= '0;
    end else begin
      taken_q <= taken_d;
      wait_q  <= wait_d;
    end
  end

  assign taken_cnt = taken_q;
  assign wait_cnt  = wait_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Branch redirect sequencer: holds the EX redirect until fetch accepts, then squashes the wrong path.
// Optional performance counters are built when BRU_PERF_CNT_EN is defined.
module pc_redirect_ctrl
  import bru_pkg::*;
#(
  parameter int PC_W       = 9,
  parameter int SQUASH_CYC = BRU_SQUASH_CYC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_pc_sel,
  input  logic [31:0]     ex_br_pc,
  input  logic            fetch_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            misalign_err,
  output logic            busy,
  output logic [31:0]     taken_cnt,
  output logic [31:0]     wait_cnt
);

  localparam int SQ_W = (SQUASH_CYC < 1) ? 1 : $clog2(SQUASH_CYC + 1);
  localparam logic [SQ_W-1:0] SQ_INIT = SQ_W'(SQUASH_CYC);
  // After acceptance, a zero-length squash window returns straight to IDLE.
  localparam bru_state_e ACCEPT_ST = (SQUASH_CYC == 0) ? IDLE : SQUASH;

  bru_state_e      state_q, state_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [SQ_W-1:0] sq_cnt_q, sq_cnt_d;
  logic            misalign_q, misalign_d;

  logic            take;
  logic            idle_take;
  logic [PC_W-1:0] aligned_pc;
  logic            unused_br_bits;

  assign take       = ex_valid & ex_pc_sel & ~ex_stall;
  assign idle_take  = (state_q == IDLE) & take;
  assign aligned_pc = {ex_br_pc[PC_W-1:1], 1'b0};
  assign unused_br_bits = ^ex_br_pc;

  // NOTE: every variable assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    sq_cnt_d   = sq_cnt_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          tgt_d      = aligned_pc;
          misalign_d = ex_br_pc[1];
          if (fetch_ready) begin
            state_d  = ACCEPT_ST;
            sq_cnt_d = SQ_INIT;
          end else begin
            state_d  = PEND;
          end
        end
      end
      PEND: begin
        if (fetch_ready) begin
          state_d  = ACCEPT_ST;
          sq_cnt_d = SQ_INIT;
        end
      end
      SQUASH: begin
        sq_cnt_d = sq_cnt_q - SQ_W'(1);
        if (sq_cnt_q == SQ_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      sq_cnt_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      sq_cnt_q   <= sq_cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Mealy on take so fetch sees the redirect in the same cycle EX resolves it.
  assign redirect_valid = idle_take | (state_q == PEND);
  assign redirect_pc    = (state_q == IDLE) ? aligned_pc : tgt_q;
  assign flush_idex     = redirect_valid;
  assign flush_ifid     = redirect_valid | (state_q == SQUASH);
  assign busy           = (state_q != IDLE);
  assign misalign_err   = misalign_q;

`ifdef BRU_PERF_CNT_EN
  bru_perf_cnt u_perf_cnt (
    .clk       (clk),
    .reset     (reset),
    .inc_taken (idle_take),
    .inc_wait  (state_q == PEND),
    .taken_cnt (taken_cnt),
    .wait_cnt  (wait_cnt)
  );
`else
  assign taken_cnt = 32'b0;
  assign wait_cnt  = 32'b0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios, then random traffic against a transaction-level model.
module tb_pc_redirect_ctrl;

  localparam int PC_W = 9;
  localparam int SQC  = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            ex_valid, ex_stall, ex_pc_sel, fetch_ready;
  logic [31:0]     ex_br_pc;
  logic            redirect_valid, flush_ifid, flush_idex, misalign_err, busy;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     taken_cnt, wait_cnt;

  pc_redirect_ctrl #(.PC_W(PC_W), .SQUASH_CYC(SQC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_pc_sel      (ex_pc_sel),
    .ex_br_pc       (ex_br_pc),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .misalign_err   (misalign_err),
    .busy           (busy),
    .taken_cnt      (taken_cnt),
    .wait_cnt       (wait_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: an outstanding redirect (pending + target) and a squash window length.
  bit          m_pending;
  logic [8:0]  m_target;
  int          m_squash_left;
  bit          m_misalign;
  logic [31:0] m_taken, m_wait;

  // Outputs captured in the most recent cycle for directed constant checks.
  logic       s_rv, s_ifid, s_idex, s_mis, s_busy;
  logic [8:0] s_pc;

  function automatic logic [8:0] align(input logic [31:0] b);
    logic [8:0] r;
    r    = b[8:0];
    r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef BRU_PERF_CNT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pending = 0; m_target = '0; m_squash_left = 0; m_misalign = 0;
    m_taken = '0; m_wait = '0;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic v, input logic st, input logic sel,
                       input logic [31:0] br, input logic fr, input logic rst);
    bit   take, accepted, e_rv;
    logic [8:0] e_pc;
    ex_valid = v; ex_stall = st; ex_pc_sel = sel; ex_br_pc = br;
    fetch_ready = fr; reset = rst;
    @(negedge clk);
    take     = v && sel && !st;
    accepted = take && !m_pending && (m_squash_left == 0);
    e_rv     = accepted || m_pending;
    e_pc     = accepted ? align(br) : m_target;
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
    if (e_rv) check("redirect_pc", {23'b0, redirect_pc}, {23'b0, e_pc});
    check("flush_idex", {31'b0, flush_idex}, {31'b0, e_rv});
    check("flush_ifid", {31'b0, flush_ifid}, {31'b0, e_rv || (m_squash_left > 0)});
    check("busy", {31'b0, busy}, {31'b0, m_pending || (m_squash_left > 0)});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_misalign});
    check("taken_cnt", taken_cnt, perf(m_taken));
    check("wait_cnt", wait_cnt, perf(m_wait));
    s_rv = redirect_valid; s_pc = redirect_pc; s_ifid = flush_ifid;
    s_idex = flush_idex; s_mis = misalign_err; s_busy = busy;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_misalign = accepted && br[1];
      if (accepted) begin
        m_taken++;
        m_target = align(br);
        if (fr) m_squash_left = SQC;
        else    m_pending = 1;
      end else if (m_pending) begin
        m_wait++;
        if (fr) begin
          m_pending = 0;
          m_squash_left = SQC;
        end
      end else if (m_squash_left > 0) begin
        m_squash_left--;
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 32'h0, 0, 0);
  endtask

  initial begin
    ex_valid = 0; ex_stall = 0; ex_pc_sel = 0; ex_br_pc = '0; fetch_ready = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 0;

    // Reset state
    idle_cycle();
    check("rst_rv", {31'b0, s_rv}, 32'd0);
    check("rst_busy", {31'b0, s_busy}, 32'd0);
    check("rst_ifid", {31'b0, s_ifid}, 32'd0);

    // Take with same-cycle fetch acceptance
    cycle(1, 0, 1, 32'h0000_0040, 1, 0);
    check("t1_rv", {31'b0, s_rv}, 32'd1);
    check("t1_pc", {23'b0, s_pc}, 32'h040);
    check("t1_idex", {31'b0, s_idex}, 32'd1);
    idle_cycle();
    check("t1_sq_ifid", {31'b0, s_ifid}, 32'd1);
    check("t1_sq_idex", {31'b0, s_idex}, 32'd0);
    idle_cycle();
    check("t1_idle", {31'b0, s_busy}, 32'd0);

    // Fetch stalls three cycles; bit 0 stripped, no misalignment
    cycle(1, 0, 1, 32'h0000_0081, 0, 0);
    check("t2_pc0", {23'b0, s_pc}, 32'h080);
    cycle(0, 0, 0, 32'h0, 0, 0);
    cycle(0, 0, 0, 32'h0, 0, 0);
    check("t2_mis", {31'b0, s_mis}, 32'd0);
    cycle(0, 0, 0, 32'h0, 1, 0);
    check("t2_idex3", {31'b0, s_idex}, 32'd1);
    check("t2_pc3", {23'b0, s_pc}, 32'h080);
    idle_cycle();
    check("t2_wait", wait_cnt, perf(32'd3));
    idle_cycle();

    // Misaligned target, and a second take while pending is ignored
    cycle(1, 0, 1, 32'h0000_0106, 0, 0);
    check("t3_pc", {23'b0, s_pc}, 32'h106);
    cycle(1, 0, 1, 32'h0000_0020, 0, 0);
    check("t3_mis_pulse", {31'b0, s_mis}, 32'd1);
    check("t3_pc_hold", {23'b0, s_pc}, 32'h106);
    cycle(0, 0, 0, 32'h0, 1, 0);
    check("t3_mis_clear", {31'b0, s_mis}, 32'd0);
    idle_cycle();
    idle_cycle();

    // Stalled take is deferred to the release cycle
    cycle(0, 0, 0, 32'h0, 0, 1);
    cycle(1, 1, 1, 32'h0000_0044, 1, 0);
    check("t4_stall0", {31'b0, s_rv}, 32'd0);
    cycle(1, 1, 1, 32'h0000_0044, 1, 0);
    check("t4_stall1", {31'b0, s_rv}, 32'd0);
    cycle(1, 0, 1, 32'h0000_0044, 1, 0);
    check("t4_release", {31'b0, s_rv}, 32'd1);
    check("t4_taken", taken_cnt, perf(32'd1));
    // Back-to-back: take in the first IDLE cycle after the squash
    cycle(0, 0, 0, 32'h0, 0, 0);
    cycle(1, 0, 1, 32'h0000_00c8, 1, 0);
    check("t5_b2b", {31'b0, s_rv}, 32'd1);
    idle_cycle();
    idle_cycle();

    // Reset while pending drops the redirect
    cycle(1, 0, 1, 32'h0000_0010, 0, 0);
    cycle(0, 0, 0, 32'h0, 0, 1);
    idle_cycle();
    check("t6_rv", {31'b0, s_rv}, 32'd0);
    check("t6_busy", {31'b0, s_busy}, 32'd0);
    check("t6_ifid", {31'b0, s_ifid}, 32'd0);
    check("t6_taken", taken_cnt, 32'd0);
    check("t6_wait", wait_cnt, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      cycle(r ? 1'b0 : 1'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) != 0), $urandom,
            1'($urandom_range(0, 2) != 0), r);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
